// File: rtl/fetch_redirect_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : fetch_redirect_ctrl_if
// Brief    : Bundle of fetch, branch, BPU and trap signals for fetch_redirect_ctrl.
// Revision : 1.0
// ============================================================================
interface fetch_redirect_ctrl_if;
  logic        fetch_ready;
  logic        fetch_req;
  logic [31:0] fetch_pc;
  logic        br_taken_ex;
  logic [31:0] br_target_ex;
  logic        bpu_taken;
  logic [31:0] bpu_target;
  logic        load_stall;
  logic        trap_req;
  logic        mret_req;
  logic [31:0] mtvec;
  logic [31:0] mepc;
  logic        trap_ack;
  logic        trap_active;
  logic        freeze_if_id;
  logic        flush_if_id;

  // Controller side
  modport master (
    input  fetch_ready, br_taken_ex, br_target_ex, bpu_taken, bpu_target,
           load_stall, trap_req, mret_req, mtvec, mepc,
    output fetch_req, fetch_pc, trap_ack, trap_active, freeze_if_id, flush_if_id
  );

  // Environment side (pipeline, CSR logic, imem)
  modport slave (
    output fetch_ready, br_taken_ex, br_target_ex, bpu_taken, bpu_target,
           load_stall, trap_req, mret_req, mtvec, mepc,
    input  fetch_req, fetch_pc, trap_ack, trap_active, freeze_if_id, flush_if_id
  );
endinterface
`default_nettype wire

// File: rtl/fetch_redirect_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : fetch_redirect_ctrl
// Brief    : Fetch PC sequencer arbitrating trap/mret, branch, BPU and stalls.
// Revision : 1.0
// ============================================================================
module fetch_redirect_ctrl #(
  parameter logic [31:0] RESET_PC     = 32'h0000_0000,
  parameter int unsigned DRAIN_CYCLES = 3
) (
  input  wire logic            CLK,
  input  wire logic            RST,
  fetch_redirect_ctrl_if.master bus
);

  localparam logic [1:0] c_IDLE     = 2'd0;
  localparam logic [1:0] c_RUN      = 2'd1;
  localparam logic [1:0] c_DRAIN    = 2'd2;
  localparam logic [1:0] c_REDIRECT = 2'd3;

  localparam logic [2:0] c_DRAIN_LOAD = 3'(DRAIN_CYCLES - 1);

  logic [1:0]  r_state;
  logic [31:0] r_pc;
  logic        r_flush;
  logic        r_kind;
  logic [2:0]  r_cnt;

  logic        w_run;
  logic        w_fetch_req;
  logic [31:0] w_br_tgt;
  logic [31:0] w_bpu_tgt;
  logic [31:0] w_trap_tgt;
  logic        w_unused_bits;

  assign w_run       = (r_state == c_RUN);
  assign w_fetch_req = w_run & ~bus.load_stall;

  assign w_br_tgt   = {bus.br_target_ex[31:2], 2'b00};
  assign w_bpu_tgt  = {bus.bpu_target[31:2], 2'b00};
  assign w_trap_tgt = r_kind ? {bus.mepc[31:2], 2'b00} : {bus.mtvec[31:2], 2'b00};

  // Low address bits of every target are discarded by design.
  assign w_unused_bits = &{1'b0, bus.br_target_ex[1:0], bus.bpu_target[1:0],
                           bus.mepc[1:0], bus.mtvec[1:0]};

  assign bus.fetch_req    = w_fetch_req;
  assign bus.fetch_pc     = r_pc;
  assign bus.freeze_if_id = ~w_run | bus.load_stall | (w_fetch_req & ~bus.fetch_ready);
  assign bus.trap_ack     = (r_state == c_REDIRECT);
  assign bus.trap_active  = (r_state == c_DRAIN) | (r_state == c_REDIRECT);
  assign bus.flush_if_id  = r_flush;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state <= c_IDLE;
      r_pc    <= RESET_PC;
      r_flush <= 1'b0;
      r_kind  <= 1'b0;
      r_cnt   <= 3'd0;
    end else begin
      case (r_state)
        c_IDLE: begin
          r_state <= c_RUN;
          r_flush <= 1'b0;
        end

        c_RUN: begin
          r_flush <= 1'b0;
          if (bus.trap_req | bus.mret_req) begin
            // A simultaneous trap and mret resolves to the trap vector.
            r_kind  <= bus.mret_req & ~bus.trap_req;
            r_cnt   <= c_DRAIN_LOAD;
            r_state <= c_DRAIN;
            r_flush <= 1'b1;
          end else if (bus.br_taken_ex) begin
            r_pc    <= w_br_tgt;
            r_flush <= 1'b1;
          end else if (bus.load_stall) begin
            r_pc <= r_pc;
          end else if (bus.fetch_ready) begin
            r_pc <= bus.bpu_taken ? w_bpu_tgt : (r_pc + 32'd4);
          end
        end

        c_DRAIN: begin
          r_flush <= 1'b1;
          if (r_cnt == 3'd0) begin
            r_state <= c_REDIRECT;
          end else begin
            r_cnt <= r_cnt - 3'd1;
          end
        end

        c_REDIRECT: begin
          r_pc    <= w_trap_tgt;
          r_flush <= 1'b0;
          r_state <= c_RUN;
        end

        default: begin
          r_state <= c_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fetch_redirect_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_redirect_ctrl
// Brief    : Self-checking bench: directed vector table, reset abort, random vs model.
// Revision : 1.0
// ============================================================================
module tb_fetch_redirect_ctrl;

  localparam logic [31:0] RESET_PC     = 32'h0000_0000;
  localparam int          DRAIN_CYCLES = 3;

  typedef struct {
    logic        rdy;
    logic        br;
    logic [31:0] brt;
    logic        bp;
    logic [31:0] bpt;
    logic        ls;
    logic        tr;
    logic        mr;
    logic        e_req;
    logic        e_frz;
    logic        e_ack;
    logic        e_act;
    logic [31:0] e_pc;
    logic        e_fl;
  } vec_t;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  int   total = 0;
  int   bad   = 0;

  fetch_redirect_ctrl_if intf();

  fetch_redirect_ctrl #(
    .RESET_PC    (RESET_PC),
    .DRAIN_CYCLES(DRAIN_CYCLES)
  ) dut (
    .CLK(CLK),
    .RST(RST),
    .bus(intf)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(
    input logic rdy, input logic br, input logic [31:0] brt,
    input logic bp, input logic [31:0] bpt, input logic ls,
    input logic tr, input logic mr,
    input logic e_req, input logic e_frz, input logic e_ack, input logic e_act,
    input logic [31:0] e_pc, input logic e_fl);
    vec_t v;
    v.rdy = rdy; v.br = br; v.brt = brt; v.bp = bp; v.bpt = bpt; v.ls = ls;
    v.tr = tr; v.mr = mr; v.e_req = e_req; v.e_frz = e_frz; v.e_ack = e_ack;
    v.e_act = e_act; v.e_pc = e_pc; v.e_fl = e_fl;
    return v;
  endfunction

  task automatic drive(input vec_t v);
    intf.fetch_ready  = v.rdy;
    intf.br_taken_ex  = v.br;
    intf.br_target_ex = v.brt;
    intf.bpu_taken    = v.bp;
    intf.bpu_target   = v.bpt;
    intf.load_stall   = v.ls;
    intf.trap_req     = v.tr;
    intf.mret_req     = v.mr;
  endtask

  // Inputs are applied 1 time unit after a rising edge; outputs are sampled mid-cycle
  // and again 1 time unit after the next rising edge.
  task automatic step(input string tag, input vec_t v);
    drive(v);
    #4;
    chk({tag, ".fetch_req"},    32'(intf.fetch_req),    32'(v.e_req));
    chk({tag, ".freeze_if_id"}, 32'(intf.freeze_if_id), 32'(v.e_frz));
    chk({tag, ".trap_ack"},     32'(intf.trap_ack),     32'(v.e_ack));
    chk({tag, ".trap_active"},  32'(intf.trap_active),  32'(v.e_act));
    @(posedge CLK);
    #1;
    chk({tag, ".fetch_pc"},     intf.fetch_pc,          v.e_pc);
    chk({tag, ".flush_if_id"},  32'(intf.flush_if_id),  32'(v.e_fl));
  endtask

  task automatic do_reset();
    drive(mk(0,0,0,0,0,0,0,0, 0,0,0,0,0,0));
    RST = 1'b1;
    @(posedge CLK);
    #1;
    chk("rst.fetch_pc",     intf.fetch_pc,          RESET_PC);
    chk("rst.fetch_req",    32'(intf.fetch_req),    32'd0);
    chk("rst.freeze_if_id", 32'(intf.freeze_if_id), 32'd1);
    chk("rst.flush_if_id",  32'(intf.flush_if_id),  32'd0);
    chk("rst.trap_ack",     32'(intf.trap_ack),     32'd0);
    chk("rst.trap_active",  32'(intf.trap_active),  32'd0);
    RST = 1'b0;
  endtask

  // Reference model: trap sequence expressed as a countdown of remaining non-fetch cycles.
  logic        m_idle;
  int          m_busy;
  logic        m_kind;
  logic [31:0] m_pc;
  logic        m_fl;

  initial begin
    vec_t        tbl[$];
    vec_t        v;
    logic        req_tr, req_mr, in_run;
    int          ack_seen;

    intf.mtvec = 32'h0000_1001;
    intf.mepc  = 32'h0000_0300;
    do_reset();

    // ---------------- directed table ----------------
    tbl.push_back(mk(1,0,0,0,0,0,0,0, 0,1,0,0, 32'h0000_0000,0)); // IDLE
    tbl.push_back(mk(1,0,0,0,0,0,0,0, 1,0,0,0, 32'h0000_0004,0));
    tbl.push_back(mk(1,0,0,0,0,0,0,0, 1,0,0,0, 32'h0000_0008,0));
    tbl.push_back(mk(1,0,0,0,0,0,0,0, 1,0,0,0, 32'h0000_000C,0));
    tbl.push_back(mk(1,0,0,0,0,0,0,0, 1,0,0,0, 32'h0000_0010,0));
    tbl.push_back(mk(0,0,0,0,0,0,0,0, 1,1,0,0, 32'h0000_0010,0)); // imem wait
    tbl.push_back(mk(0,0,0,0,0,0,0,0, 1,1,0,0, 32'h0000_0010,0));
    tbl.push_back(mk(1,0,0,0,0,0,0,0, 1,0,0,0, 32'h0000_0014,0));
    tbl.push_back(mk(1,0,0,0,0,1,0,0, 0,1,0,0, 32'h0000_0014,0)); // load stall
    tbl.push_back(mk(0,1,32'h200,1,32'h80,0,0,0, 1,1,0,0, 32'h0000_0200,1)); // br beats bpu
    tbl.push_back(mk(1,0,0,1,32'h82,0,0,0, 1,0,0,0, 32'h0000_0080,0));
    tbl.push_back(mk(1,1,32'hFFFF_FFFE,0,0,0,0,0, 1,0,0,0, 32'hFFFF_FFFC,1));
    tbl.push_back(mk(1,0,0,0,0,0,0,0, 1,0,0,0, 32'h0000_0000,0)); // wrap
    tbl.push_back(mk(1,1,32'h44,0,0,1,0,0, 0,1,0,0, 32'h0000_0044,1)); // br beats stall
    tbl.push_back(mk(1,0,0,1,32'h90,1,0,0, 0,1,0,0, 32'h0000_0044,0)); // stall beats bpu
    tbl.push_back(mk(1,0,0,0,0,0,0,0, 1,0,0,0, 32'h0000_0048,0));
    tbl.push_back(mk(1,0,0,0,0,0,1,0, 1,0,0,0, 32'h0000_0048,1)); // trap
    tbl.push_back(mk(1,0,0,0,0,0,1,0, 0,1,0,1, 32'h0000_0048,1));
    tbl.push_back(mk(1,1,32'h500,1,32'h600,1,1,0, 0,1,0,1, 32'h0000_0048,1)); // ignored
    tbl.push_back(mk(1,0,0,0,0,0,1,0, 0,1,0,1, 32'h0000_0048,1));
    tbl.push_back(mk(1,0,0,0,0,0,1,0, 0,1,1,1, 32'h0000_1000,0)); // REDIRECT
    tbl.push_back(mk(1,0,0,0,0,0,0,0, 1,0,0,0, 32'h0000_1004,0));
    tbl.push_back(mk(1,0,0,0,0,0,1,1, 1,0,0,0, 32'h0000_1004,1)); // trap+mret
    tbl.push_back(mk(1,0,0,0,0,0,1,1, 0,1,0,1, 32'h0000_1004,1));
    tbl.push_back(mk(1,0,0,0,0,0,1,1, 0,1,0,1, 32'h0000_1004,1));
    tbl.push_back(mk(1,0,0,0,0,0,1,1, 0,1,0,1, 32'h0000_1004,1));
    tbl.push_back(mk(1,0,0,0,0,0,1,1, 0,1,1,1, 32'h0000_1000,0));
    tbl.push_back(mk(1,0,0,0,0,0,0,1, 1,0,0,0, 32'h0000_1000,1)); // mret alone
    tbl.push_back(mk(1,0,0,0,0,0,0,0, 0,1,0,1, 32'h0000_1000,1)); // request dropped
    tbl.push_back(mk(1,0,0,0,0,0,0,0, 0,1,0,1, 32'h0000_1000,1));
    tbl.push_back(mk(1,0,0,0,0,0,0,0, 0,1,0,1, 32'h0000_1000,1));
    tbl.push_back(mk(1,0,0,0,0,0,0,0, 0,1,1,1, 32'h0000_0300,0));
    tbl.push_back(mk(1,0,0,0,0,0,0,0, 1,0,0,0, 32'h0000_0304,0));
    for (int i = 0; i < tbl.size(); i++) begin
      step($sformatf("tbl%0d", i), tbl[i]);
    end

    // ---------------- reset during second DRAIN cycle ----------------
    ack_seen = 0;
    drive(mk(1,0,0,0,0,0,1,0, 0,0,0,0,0,0));
    @(posedge CLK); #1;
    chk("rstd.enter_drain", 32'(intf.trap_active), 32'd1);
    if (intf.trap_ack) ack_seen++;
    @(posedge CLK); #1;
    if (intf.trap_ack) ack_seen++;
    #2;
    RST = 1'b1;
    #1;
    chk("rstd.async_pc",     intf.fetch_pc,          RESET_PC);
    chk("rstd.async_active", 32'(intf.trap_active),  32'd0);
    chk("rstd.async_freeze", 32'(intf.freeze_if_id), 32'd1);
    chk("rstd.async_flush",  32'(intf.flush_if_id),  32'd0);
    intf.trap_req = 1'b0;
    @(posedge CLK); #1;
    RST = 1'b0;
    if (intf.trap_ack) ack_seen++;
    step("rstd.idle", mk(1,0,0,0,0,0,0,0, 0,1,0,0, RESET_PC,0));
    if (intf.trap_ack) ack_seen++;
    step("rstd.run0", mk(1,0,0,0,0,0,0,0, 1,0,0,0, RESET_PC + 32'd4,0));
    chk("rstd.no_ack", 32'(ack_seen), 32'd0);

    // ---------------- random vs reference model ----------------
    do_reset();
    m_idle = 1'b1; m_busy = 0; m_kind = 1'b0; m_pc = RESET_PC; m_fl = 1'b0;
    req_tr = 1'b0; req_mr = 1'b0;
    for (int c = 0; c < 600; c++) begin
      intf.mtvec = $urandom;
      intf.mepc  = $urandom;
      if (!req_tr && !req_mr && $urandom_range(0, 24) == 0) begin
        case ($urandom_range(0, 2))
          0: req_tr = 1'b1;
          1: req_mr = 1'b1;
          default: begin req_tr = 1'b1; req_mr = 1'b1; end
        endcase
      end
      v.rdy = ($urandom_range(0, 3) != 0);
      v.br  = ($urandom_range(0, 7) == 0);
      v.brt = $urandom;
      v.bp  = ($urandom_range(0, 3) == 0);
      v.bpt = $urandom;
      v.ls  = ($urandom_range(0, 5) == 0);
      v.tr  = req_tr;
      v.mr  = req_mr;

      in_run  = !m_idle && (m_busy == 0);
      v.e_req = in_run && !v.ls;
      v.e_frz = !in_run || v.ls || (v.e_req && !v.rdy);
      v.e_ack = (m_busy == 1);
      v.e_act = (m_busy > 0);

      if (m_idle) begin
        m_idle = 1'b0;
        m_fl   = 1'b0;
      end else if (m_busy > 0) begin
        if (m_busy == 1) begin
          m_pc = (m_kind ? intf.mepc : intf.mtvec) & 32'hFFFF_FFFC;
          m_fl = 1'b0;
        end else begin
          m_fl = 1'b1;
        end
        m_busy--;
      end else begin
        m_fl = 1'b0;
        if (v.tr || v.mr) begin
          m_kind = v.mr && !v.tr;
          m_busy = DRAIN_CYCLES + 1;
          m_fl   = 1'b1;
        end else if (v.br) begin
          m_pc = v.brt & 32'hFFFF_FFFC;
          m_fl = 1'b1;
        end else if (!v.ls && v.rdy) begin
          m_pc = v.bp ? (v.bpt & 32'hFFFF_FFFC) : (m_pc + 32'd4);
        end
      end
      v.e_pc = m_pc;
      v.e_fl = m_fl;

      step($sformatf("rnd%0d", c), v);
      if (v.e_ack) begin
        req_tr = 1'b0;
        req_mr = 1'b0;
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
